// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter used as the shared timeout/delay primitive.
//   - A producer loads a terminal value over a valid/ready handshake.
//   - start arms the timer. It counts down by one per clock and emits a
//     one-cycle done pulse when the count reaches zero.
//   - expired_cnt counts done pulses and saturates at all-ones.
//   Optional build macro: COUNTDOWN_AUTO_RELOAD_EN
//     When defined, an expiry in RUN reloads the last loaded value, so done
//     repeats periodically until stop or pause. A zero reload value still
//     returns the timer to IDLE.
//     When undefined, the timer is one-shot and the reload register is absent.
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] expired_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if (value == CNT_MAX) begin
      result = CNT_MAX;
    end else begin
      result = value + CNT_ONE;
    end
    return result;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic             done_r;
  logic             done_s;
  logic [WIDTH-1:0] expired_r;
  logic [WIDTH-1:0] expired_s;
  logic             load_acc_s;
  logic [WIDTH-1:0] eff_count_s;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
`endif

  // Load handshake: accepted outside RUN unless a higher-priority stop or
  // pause is present on the same edge.
  always_comb begin
    load_acc_s = 1'b0;
    if ((state_r != ST_RUN) && load_valid && !stop && !pause) begin
      load_acc_s = 1'b1;
    end else begin
      load_acc_s = 1'b0;
    end
    // A start on the same edge as an accepted load arms with the new value.
    if (load_acc_s) begin
      eff_count_s = load_value;
    end else begin
      eff_count_s = count_r;
    end
  end

  // Next-state and next-datapath logic; priority stop > pause > load > start > decrement.
  always_comb begin
    state_s = state_r;
    count_s = eff_count_s;
    done_s  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    if (load_acc_s) begin
      reload_s = load_value;
    end else begin
      reload_s = reload_r;
    end
`endif
    case (state_r)
      ST_IDLE: begin
        if (stop || pause) begin
          state_s = ST_IDLE;
        end else if (start) begin
          if (eff_count_s != CNT_ZERO) begin
            state_s = ST_RUN;
          end else begin
            // Arming with zero expires immediately without entering RUN.
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (pause) begin
          state_s = ST_HOLD;
        end else if (start) begin
          if (eff_count_s != CNT_ZERO) begin
            state_s = ST_RUN;
          end else begin
            // A zero reloaded while held expires rather than running from zero.
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (pause) begin
          state_s = ST_HOLD;
        end else if (count_r > CNT_ONE) begin
          count_s = count_r - CNT_ONE;
          state_s = ST_RUN;
        end else if (count_r == CNT_ONE) begin
          done_s = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (reload_r != CNT_ZERO) begin
            count_s = reload_r;
            state_s = ST_RUN;
          end else begin
            count_s = CNT_ZERO;
            state_s = ST_IDLE;
          end
`else
          count_s = CNT_ZERO;
          state_s = ST_IDLE;
`endif
        end else begin
          // RUN with a zero count is unreachable; fall back to IDLE quietly.
          count_s = CNT_ZERO;
          state_s = ST_IDLE;
        end
      end
      default: begin
        // Illegal encoding: recover to IDLE, keep the count.
        state_s = ST_IDLE;
        count_s = count_r;
      end
    endcase
    if (done_s) begin
      expired_s = sat_inc(expired_r);
    end else begin
      expired_s = expired_r;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      done_r    <= 1'b0;
      expired_r <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      done_r    <= done_s;
      expired_r <= expired_s;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Reload value register, captured on every accepted load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_r <= CNT_ZERO;
    end else begin
      reload_r <= reload_s;
    end
  end
`endif

  assign count       = count_r;
  assign done        = done_r;
  assign expired_cnt = expired_r;
  assign busy        = (state_r == ST_RUN);
  assign load_ready  = (state_r != ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed, table-driven bench for countdown_timer (WIDTH=5).
//   Covers the one-shot build by default. With COUNTDOWN_AUTO_RELOAD_EN
//   defined, it runs the periodic-reload sequence instead.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int WIDTH = 5;

  typedef struct {
    logic             lv;
    logic [WIDTH-1:0] val;
    logic             st;
    logic             pa;
    logic             sp;
    logic [WIDTH-1:0] exp_count;
    logic             exp_busy;
    logic             exp_done;
    logic [WIDTH-1:0] exp_expired;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             start;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] expired_cnt;

  int checks;
  int errors;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_value  (load_value),
    .load_ready  (load_ready),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .expired_cnt (expired_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [WIDTH-1:0] val,
                       input logic st, input logic pa, input logic sp);
    load_valid = lv;
    load_value = val;
    start      = st;
    pause      = pa;
    stop       = sp;
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int c, input int b,
                               input int d, input int e);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".busy"}, int'(busy), b);
    check({tag, ".done"}, int'(done), d);
    check({tag, ".expired"}, int'(expired_cnt), e);
    check({tag, ".ready"}, int'(load_ready), (b != 0) ? 0 : 1);
  endtask

  function automatic vec_t mk(input logic lv, input int val, input logic st,
                              input logic pa, input logic sp, input int c,
                              input logic b, input logic d, input int e);
    vec_t v;
    v.lv          = lv;
    v.val         = val[WIDTH-1:0];
    v.st          = st;
    v.pa          = pa;
    v.sp          = sp;
    v.exp_count   = c[WIDTH-1:0];
    v.exp_busy    = b;
    v.exp_done    = d;
    v.exp_expired = e[WIDTH-1:0];
    return v;
  endfunction

  initial begin
    vec_t vecs[30];
    int   exp_model;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_outputs("reset", 0, 0, 0, 0);
    reset = 1'b0;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // lv val st pa sp | count busy done expired
    // load 5 + start on the same edge, then five decrements
    vecs[0]  = mk(1'b1,  5, 1'b1, 1'b0, 1'b0,  5, 1'b1, 1'b0, 0);
    vecs[1]  = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  4, 1'b1, 1'b0, 0);
    vecs[2]  = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0, 0);
    vecs[3]  = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  2, 1'b1, 1'b0, 0);
    vecs[4]  = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b0, 0);
    vecs[5]  = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b1, 1);
    vecs[6]  = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1);
    // load 4, one decrement, pause 3 cycles, resume, load ignored while busy
    vecs[7]  = mk(1'b1,  4, 1'b1, 1'b0, 1'b0,  4, 1'b1, 1'b0, 1);
    vecs[8]  = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0, 1);
    vecs[9]  = mk(1'b0,  0, 1'b0, 1'b1, 1'b0,  3, 1'b0, 1'b0, 1);
    vecs[10] = mk(1'b0,  0, 1'b0, 1'b1, 1'b0,  3, 1'b0, 1'b0, 1);
    vecs[11] = mk(1'b0,  0, 1'b0, 1'b1, 1'b0,  3, 1'b0, 1'b0, 1);
    vecs[12] = mk(1'b0,  0, 1'b1, 1'b0, 1'b0,  3, 1'b1, 1'b0, 1);
    vecs[13] = mk(1'b1, 20, 1'b0, 1'b0, 1'b0,  2, 1'b1, 1'b0, 1);
    vecs[14] = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1);
    vecs[15] = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b1, 2);
    // load 0 + start: immediate done, no RUN
    vecs[16] = mk(1'b1,  0, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b1, 3);
    vecs[17] = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 3);
    // stop during RUN at count 2 keeps the count, no done
    vecs[18] = mk(1'b1,  3, 1'b1, 1'b0, 1'b0,  3, 1'b1, 1'b0, 3);
    vecs[19] = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  2, 1'b1, 1'b0, 3);
    vecs[20] = mk(1'b0,  0, 1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b0, 3);
    vecs[21] = mk(1'b0,  0, 1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 3);
    // restart from retained count, pause, load in HOLD, resume, stop
    vecs[22] = mk(1'b0,  0, 1'b1, 1'b0, 1'b0,  2, 1'b1, 1'b0, 3);
    vecs[23] = mk(1'b0,  0, 1'b0, 1'b1, 1'b0,  2, 1'b0, 1'b0, 3);
    vecs[24] = mk(1'b1,  6, 1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b0, 3);
    vecs[25] = mk(1'b0,  0, 1'b1, 1'b0, 1'b0,  6, 1'b1, 1'b0, 3);
    vecs[26] = mk(1'b0,  0, 1'b0, 1'b0, 1'b1,  6, 1'b0, 1'b0, 3);
    // plain load in IDLE, then stop outranks a load
    vecs[27] = mk(1'b1, 31, 1'b0, 1'b0, 1'b0, 31, 1'b0, 1'b0, 3);
    vecs[28] = mk(1'b0,  0, 1'b0, 1'b0, 1'b0, 31, 1'b0, 1'b0, 3);
    vecs[29] = mk(1'b1,  7, 1'b0, 1'b0, 1'b1, 31, 1'b0, 1'b0, 3);

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].lv, vecs[i].val, vecs[i].st, vecs[i].pa, vecs[i].sp);
      tick();
      check_outputs($sformatf("vec%0d", i), int'(vecs[i].exp_count),
                    int'(vecs[i].exp_busy), int'(vecs[i].exp_done),
                    int'(vecs[i].exp_expired));
    end

    // All-ones count runs 31 decrements before expiring.
    drive(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_outputs("max_start", 31, 1, 0, 3);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 30; n >= 1; n--) begin
      tick();
      check("max_run.count", int'(count), n);
      check("max_run.done", int'(done), 0);
    end
    tick();
    check_outputs("max_expire", 0, 0, 1, 4);

    // Forty one-shot expiries: expired_cnt must stop at 31.
    exp_model = 4;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
      tick();
      check("sat_arm.busy", int'(busy), 1);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      exp_model = (exp_model < 31) ? exp_model + 1 : 31;
      check("sat.done", int'(done), 1);
      check("sat.expired", int'(expired_cnt), exp_model);
    end
    check("sat.final", int'(expired_cnt), 31);
`else
    // Auto-reload: load 3, start, done every third edge while busy stays high.
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check_outputs("ar_start", 3, 1, 0, 0);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int p = 1; p <= 3; p++) begin
      tick();
      check_outputs($sformatf("ar%0d_a", p), 2, 1, 0, p - 1);
      tick();
      check_outputs($sformatf("ar%0d_b", p), 1, 1, 0, p - 1);
      tick();
      check_outputs($sformatf("ar%0d_c", p), 3, 1, 1, p);
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outputs("ar_stop", 3, 0, 0, 3);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a count of 13.
    drive(1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("pre_reset.count", int'(count), 13);
    check("pre_reset.busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    check_outputs("post_reset", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
